// File: rtl/change_dispenser.sv
// Change dispenser: pays out owed change one coin at a time over a valid/ack
// handshake, choosing the largest denomination that fits and is still in stock.
module change_dispenser #(
    parameter int PRICE      = 80,
    parameter int V0         = 5,
    parameter int V1         = 10,
    parameter int V2         = 25,
    parameter int V3         = 50,
    parameter int STOCK_W    = 4,
    parameter int INIT_STOCK = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       refund,
    input  logic [7:0] amount,
    input  logic       refill,
    input  logic       coin_ack,
    output logic       coin_valid,
    output logic [1:0] coin_sel,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [7:0] remaining
);

    typedef enum logic [2:0] {IDLE, SELECT, OFFER, DONE, ERR} state_t;

    state_t state, state_next;

    logic [STOCK_W-1:0] stock [4];
    logic [7:0]         coin_value [4];
    logic [7:0]         start_amount;
    logic               pick_found;
    logic [1:0]         pick_code;

    assign coin_value[0] = 8'(V0);
    assign coin_value[1] = 8'(V1);
    assign coin_value[2] = 8'(V2);
    assign coin_value[3] = 8'(V3);

    // A sale below the price owes nothing rather than wrapping around.
    always_comb begin
        start_amount = 8'd0;
        if (refund)
            start_amount = amount;
        else if (amount >= 8'(PRICE))
            start_amount = amount - 8'(PRICE);
    end

    // Ascending scan so the highest eligible code wins.
    always_comb begin
        pick_found = 1'b0;
        pick_code  = 2'd0;
        for (int k = 0; k < 4; k++) begin
            if (coin_value[k] <= remaining && stock[k] != '0) begin
                pick_found = 1'b1;
                pick_code  = 2'(k);
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = SELECT;
            SELECT: begin
                if (remaining == 8'd0)
                    state_next = DONE;
                else if (pick_found)
                    state_next = OFFER;
                else
                    state_next = ERR;
            end
            OFFER:   if (coin_ack) state_next = SELECT;
            DONE:    state_next = IDLE;
            ERR:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign coin_valid = (state == OFFER);
    assign busy       = (state != IDLE);
    assign done       = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            remaining <= 8'd0;
            coin_sel  <= 2'd0;
            err       <= 1'b0;
            for (int k = 0; k < 4; k++)
                stock[k] <= STOCK_W'(INIT_STOCK);
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (start) begin
                        remaining <= start_amount;
                        err       <= 1'b0;
                    end
                    if (refill) begin
                        for (int k = 0; k < 4; k++)
                            stock[k] <= STOCK_W'(INIT_STOCK);
                    end
                end
                SELECT: begin
                    if (remaining != 8'd0) begin
                        if (pick_found)
                            coin_sel <= pick_code;
                        else
                            err <= 1'b1;
                    end
                end
                // Paying a coin and consuming its stock happen on the same edge.
                OFFER: begin
                    if (coin_ack) begin
                        remaining       <= remaining - coin_value[coin_sel];
                        stock[coin_sel] <= stock[coin_sel] - STOCK_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_change_dispenser.sv
// Self-checking bench for change_dispenser: directed vector table, hand-written
// corner sequences and randomized transactions against a greedy payout model.
module tb_change_dispenser;

    logic       clk = 1'b0;
    logic       rst, start, refund, refill, coin_ack;
    logic [7:0] amount;
    logic       coin_valid, busy, done, err;
    logic [1:0] coin_sel;
    logic [7:0] remaining;

    always #5 clk = ~clk;

    change_dispenser dut (
        .clk(clk), .rst(rst), .start(start), .refund(refund), .amount(amount),
        .refill(refill), .coin_ack(coin_ack), .coin_valid(coin_valid),
        .coin_sel(coin_sel), .busy(busy), .done(done), .err(err),
        .remaining(remaining)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    int vals[4] = '{5, 10, 25, 50};
    int mstock[4];
    int exp_coins[$];
    int got_coins[$];
    int exp_rem;
    int exp_err;

    typedef struct {
        int amt;
        bit rf;
        int delay;
        int ncoins;
        int first;
        int rem;
        int er;
    } vec_t;

    vec_t vecs[7];

    task automatic checkOutput(input string name, input int actual, input int expected);
        n_cmp++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Greedy payout from the rules: largest coin not above the debt and in stock.
    task automatic modelTxn(input int amt, input bit rf);
        int k;
        exp_coins.delete();
        exp_err = 0;
        exp_rem = rf ? amt : ((amt >= 80) ? amt - 80 : 0);
        while (exp_rem > 0) begin
            k = -1;
            for (int j = 0; j < 4; j++)
                if (vals[j] <= exp_rem && mstock[j] > 0) k = j;
            if (k < 0) begin
                exp_err = 1;
                break;
            end
            exp_coins.push_back(k);
            exp_rem -= vals[k];
            mstock[k]--;
        end
    endtask

    task automatic checkStock(input string name);
        for (int j = 0; j < 4; j++)
            checkOutput(name, int'(dut.stock[j]), mstock[j]);
    endtask

    // One full transaction with a hopper that acks after 'delay' offer cycles,
    // or holds ack high throughout when 'hold' is set.
    task automatic applyStimulus(input int amt, input bit rf, input int delay,
                                 input bit hold, input bit noise,
                                 output int ncoins, output int first);
        int cyc;
        int wait_cnt;
        int offer_sel;
        int eff_delay;
        modelTxn(amt, rf);
        eff_delay = hold ? 0 : delay;
        amount = 8'(amt);
        refund = rf;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        refund = 1'b0;
        amount = 8'd0;
        checkOutput("busy_after_start", busy, 1);
        checkOutput("err_cleared_by_start", err, 0);
        got_coins.delete();
        cyc       = 1;
        wait_cnt  = 0;
        offer_sel = -1;
        coin_ack  = hold;
        while (cyc < 600) begin
            if (done || (busy && err)) break;
            if (coin_valid) begin
                if (offer_sel < 0) begin
                    offer_sel = coin_sel;
                    wait_cnt  = 0;
                end else begin
                    checkOutput("coin_sel_stable", coin_sel, offer_sel);
                end
                if (hold || wait_cnt == delay) begin
                    got_coins.push_back(coin_sel);
                    offer_sel = -1;
                    coin_ack  = 1'b1;
                end
                wait_cnt++;
            end
            if (noise && busy) begin
                start  = 1'b1;
                refill = 1'b1;
                refund = 1'($urandom);
                amount = 8'($urandom);
            end
            tick();
            cyc++;
            start  = 1'b0;
            refill = 1'b0;
            refund = 1'b0;
            amount = 8'd0;
            if (!hold) coin_ack = 1'b0;
        end
        coin_ack = 1'b0;
        if (cyc >= 600) begin
            checkOutput("txn_timeout", 0, 1);
        end else begin
            checkOutput("end_err", err, exp_err);
            checkOutput("end_done", done, exp_err ? 0 : 1);
            checkOutput("latency", cyc, 2 + exp_coins.size() * (eff_delay + 2));
            checkOutput("remaining_end", remaining, exp_rem);
        end
        checkOutput("coin_count", got_coins.size(), exp_coins.size());
        for (int i = 0; i < got_coins.size() && i < exp_coins.size(); i++)
            checkOutput("coin_code", got_coins[i], exp_coins[i]);
        ncoins = got_coins.size();
        first  = (got_coins.size() > 0) ? got_coins[0] : -1;
        tick();
        checkOutput("idle_busy", busy, 0);
        checkOutput("done_one_cycle", done, 0);
        checkOutput("err_sticky", err, exp_err);
        checkOutput("remaining_held", remaining, exp_rem);
    endtask

    initial begin
        int nc, fc, saved_rem;
        rst = 1'b1; start = 1'b0; refund = 1'b0; refill = 1'b0;
        coin_ack = 1'b0; amount = 8'd0;
        for (int j = 0; j < 4; j++) mstock[j] = 8;
        tick();
        tick();
        checkOutput("rst_coin_valid", coin_valid, 0);
        checkOutput("rst_coin_sel", coin_sel, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_err", err, 0);
        checkOutput("rst_remaining", remaining, 0);
        checkStock("rst_stock");
        rst = 1'b0;
        tick();

        vecs[0] = '{115, 1'b0, 0, 2, 2, 0, 0};
        vecs[1] = '{80,  1'b0, 0, 0, -1, 0, 0};
        vecs[2] = '{45,  1'b1, 3, 3, 2, 0, 0};
        vecs[3] = '{83,  1'b0, 0, 0, -1, 3, 1};
        vecs[4] = '{80,  1'b0, 1, 0, -1, 0, 0};
        vecs[5] = '{50,  1'b0, 0, 0, -1, 0, 0};
        vecs[6] = '{255, 1'b1, 2, 6, 3, 0, 0};
        for (int i = 0; i < 7; i++) begin
            applyStimulus(vecs[i].amt, vecs[i].rf, vecs[i].delay, 1'b0, 1'b0, nc, fc);
            checkOutput("vec_ncoins", nc, vecs[i].ncoins);
            checkOutput("vec_first", fc, vecs[i].first);
            checkOutput("vec_remaining", remaining, vecs[i].rem);
            checkOutput("vec_err", err, vecs[i].er);
        end
        checkOutput("vec_stock0", int'(dut.stock[0]), 7);
        checkOutput("vec_stock1", int'(dut.stock[1]), 5);
        checkOutput("vec_stock2", int'(dut.stock[2]), 6);
        checkOutput("vec_stock3", int'(dut.stock[3]), 3);

        // coin_ack while idle must change nothing
        saved_rem = remaining;
        coin_ack = 1'b1;
        tick(); tick(); tick();
        coin_ack = 1'b0;
        checkOutput("idle_ack_busy", busy, 0);
        checkOutput("idle_ack_remaining", remaining, saved_rem);
        checkStock("idle_ack_stock");

        // refill in idle
        refill = 1'b1;
        tick();
        refill = 1'b0;
        for (int j = 0; j < 4; j++) mstock[j] = 8;
        checkStock("refill_stock");

        // ack held high through SELECT counts once per offer
        applyStimulus(115, 1'b0, 0, 1'b1, 1'b0, nc, fc);
        checkOutput("hold_ncoins", nc, 2);

        // start/refill noise while busy
        applyStimulus(200, 1'b1, 1, 1'b0, 1'b1, nc, fc);
        checkStock("noise_stock");

        // reset mid-offer drops the coin without touching stock
        amount = 8'd115; start = 1'b1;
        tick();
        start = 1'b0; amount = 8'd0;
        tick();
        checkOutput("offer_before_rst", coin_valid, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int j = 0; j < 4; j++) mstock[j] = 8;
        checkOutput("midrst_coin_valid", coin_valid, 0);
        checkOutput("midrst_busy", busy, 0);
        checkOutput("midrst_remaining", remaining, 0);
        checkOutput("midrst_coin_sel", coin_sel, 0);
        checkOutput("midrst_err", err, 0);
        checkStock("midrst_stock");
        tick();

        // exhaust the 50s, then fall back to 25s
        for (int i = 0; i < 8; i++) begin
            applyStimulus(130, 1'b0, 0, 1'b0, 1'b0, nc, fc);
            checkOutput("exh_fifty", fc, 3);
        end
        checkOutput("exh_stock3", int'(dut.stock[3]), 0);
        applyStimulus(130, 1'b0, 0, 1'b0, 1'b0, nc, fc);
        checkOutput("exh_ncoins", nc, 2);
        checkOutput("exh_first", fc, 2);

        // randomized transactions
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                refill = 1'b1;
                tick();
                refill = 1'b0;
                for (int j = 0; j < 4; j++) mstock[j] = 8;
            end
            applyStimulus(int'($urandom_range(0, 255)), 1'($urandom), int'($urandom_range(0, 2)),
                          1'b0, 1'($urandom), nc, fc);
        end
        checkStock("final_stock");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
